// File: rtl/requant_stage_if.sv
// Stream bundles for the requant stage: wide accumulator pixels in,
// framed int8 pixels out, both with valid/ready handshakes.
interface requant_in_if;
  logic signed [31:0] data;
  logic               valid;
  logic               ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

interface requant_out_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       eol;
  logic       eof;

  modport master (
    output data,
    output valid,
    input  ready,
    output eol,
    output eof
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    input  eol,
    input  eof
  );
endinterface

// File: rtl/requant_stage.sv
// Requantizes 32-bit accumulator pixels to int8 through a 3-stage pipe
// into a credit-guarded show-ahead FIFO, tagging line and frame ends.
module requant_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  requant_in_if.slave        in_s,
  requant_out_if.master      out_m,
  input  logic [15:0]        scale,
  input  logic [4:0]         shift,
  input  logic signed [7:0]  zero_point,
  input  logic               relu_en,
  input  logic [7:0]         width,
  input  logic [7:0]         height,
  output logic [CNT_W-1:0]   sat_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  logic acc;
  logic pop;

  assign acc = in_s.valid & in_s.ready;
  assign pop = out_m.valid & out_m.ready;

  // Credits cover the FIFO plus everything in flight in S1..S3.
  logic [AW:0] occ_q, occ_d;

  assign in_s.ready = (occ_q < DEPTH_C);

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      acc & ~pop: occ_d = occ_q + 1'b1;
      ~acc & pop: occ_d = occ_q - 1'b1;
      default:    occ_d = occ_q;
    endcase
  end

  // S1: multiply; per-pixel config travels with the pixel
  logic               s1_v_q;
  logic signed [48:0] s1_prod_q;
  logic [4:0]         s1_sh_q;
  logic signed [7:0]  s1_zp_q;
  logic               s1_relu_q;
  logic signed [48:0] prod_d;

  assign prod_d = in_s.data * $signed({1'b0, scale});

  // S2: round half up, arithmetic shift, add zero point
  logic               s2_v_q;
  logic signed [49:0] s2_val_q;
  logic               s2_relu_q;
  logic signed [48:0] rnd;
  logic signed [48:0] sum;
  logic signed [48:0] shifted;
  logic signed [49:0] val_d;

  always_comb begin
    rnd = '0;
    if (s1_sh_q != 5'd0) begin
      rnd = 49'sd1 <<< (s1_sh_q - 5'd1);
    end
    sum     = s1_prod_q + rnd;
    shifted = sum >>> s1_sh_q;
    val_d   = {shifted[48], shifted}
            + {{42{s1_zp_q[7]}}, s1_zp_q};
  end

  // S3: ReLU and saturation
  logic       s3_v_q;
  logic [7:0] s3_data_q;
  logic       s3_sat_q;
  logic [7:0] res_d;
  logic       sat_d;
  logic       relu_neg;
  logic       hi;
  logic       lo;

  assign relu_neg = s2_relu_q & s2_val_q[49];
  assign hi = (s2_val_q > 50'sd127);
  assign lo = ~s2_relu_q & (s2_val_q < -50'sd128);

  always_comb begin
    res_d = s2_val_q[7:0];
    sat_d = 1'b0;
    unique case (1'b1)
      relu_neg: res_d = 8'h00;
      hi: begin
        res_d = 8'h7f;
        sat_d = 1'b1;
      end
      lo: begin
        res_d = 8'h80;
        sat_d = 1'b1;
      end
      default: res_d = s2_val_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_prod_q <= '0;
      s1_sh_q   <= '0;
      s1_zp_q   <= '0;
      s1_relu_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_val_q  <= '0;
      s2_relu_q <= 1'b0;
      s3_v_q    <= 1'b0;
      s3_data_q <= '0;
      s3_sat_q  <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      s1_v_q    <= acc;
      s1_prod_q <= prod_d;
      s1_sh_q   <= shift;
      s1_zp_q   <= zero_point;
      s1_relu_q <= relu_en;
      s2_v_q    <= s1_v_q;
      s2_val_q  <= val_d;
      s2_relu_q <= s1_relu_q;
      s3_v_q    <= s2_v_q;
      s3_data_q <= res_d;
      s3_sat_q  <= sat_d & s2_v_q;
    end
  end

  // Show-ahead FIFO; last popped value is held while empty
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic [7:0]    last_q;
  logic [7:0]    head;

  assign head        = mem_q[rd_ptr_q];
  assign out_m.valid = (fcnt_q != '0);
  assign out_m.data  = out_m.valid ? head : last_q;

  always_comb begin
    fcnt_d = fcnt_q;
    unique case (1'b1)
      s3_v_q & ~pop: fcnt_d = fcnt_q + 1'b1;
      ~s3_v_q & pop: fcnt_d = fcnt_q - 1'b1;
      default:       fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      last_q   <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      if (s3_v_q) begin
        mem_q[wr_ptr_q] <= s3_data_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_q   <= head;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Framing
  state_e     state_q, state_d;
  logic [7:0] width_q, width_d;
  logic [7:0] height_q, height_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  logic       sat_clr;
  logic       is_eol;
  logic       is_eof;

  assign is_eol = (col_q == width_q - 8'd1);
  assign is_eof = is_eol & (row_q == height_q - 8'd1);
  assign out_m.eol = out_m.valid & is_eol;
  assign out_m.eof = out_m.valid & is_eof;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    sat_clr  = 1'b0;
    if (pop) begin
      unique case (1'b1)
        is_eof: begin
          col_d   = '0;
          row_d   = '0;
          state_d = IDLE;
        end
        is_eol & ~is_eof: begin
          col_d = '0;
          row_d = row_q + 8'd1;
        end
        default: col_d = col_q + 8'd1;
      endcase
    end
    if ((state_q == IDLE) && acc) begin
      state_d  = RUN;
      width_d  = width;
      height_d = height;
      sat_clr  = 1'b1;
    end
  end

  logic [CNT_W-1:0] sat_q, sat_cnt_d;

  assign sat_count = sat_q;

  always_comb begin
    sat_cnt_d = sat_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s3_v_q && s3_sat_q && !(&sat_q)) begin
      sat_cnt_d = sat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sat_q    <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_requant_stage.sv
// Directed-vector bench for requant_stage: arithmetic table plus
// back-pressure, framing and mid-stream reset sequences.
module tb_requant_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zp;
  logic        relu;
  logic [7:0]  width;
  logic [7:0]  height;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  requant_in_if  in_if ();
  requant_out_if out_if ();

  requant_stage #(
    .FIFO_DEPTH(4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_s      (in_if),
    .out_m     (out_if),
    .scale     (scale),
    .shift     (shift),
    .zero_point(zp),
    .relu_en   (relu),
    .width     (width),
    .height    (height),
    .sat_count (sat_count)
  );

  typedef struct {
    logic [31:0] pix;
    logic [15:0] sc;
    logic [4:0]  sh;
    logic [7:0]  zp;
    logic        relu;
    logic [7:0]  exp;
    logic        sat;
  } vec_t;

  vec_t tv [18];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!out_if.valid && k < 20) begin
      tick();
      k++;
    end
    chk(nm, out_if.valid, 1);
  endtask

  task automatic pop1();
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] s,
                     input logic [4:0] h,
                     input logic [7:0] z,
                     input logic r);
    scale = s;
    shift = h;
    zp    = z;
    relu  = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int exp_sat;
    int k;
    int acc_n;
    int got;
    int cyc;
    logic will_acc;
    logic will_pop;
    logic seen;
    logic [7:0] pv [8];
    logic [7:0] ev [8];

    tv[0]  = '{32'd100, 16'd256, 5'd8, 8'd0, 1'b0, 8'd100, 1'b0};
    tv[1]  = '{32'd3, 16'd1, 5'd1, 8'd0, 1'b0, 8'd2, 1'b0};
    tv[2]  = '{-32'sd3, 16'd1, 5'd1, 8'd0, 1'b0, 8'hff, 1'b0};
    tv[3]  = '{32'd20, 16'd1, 5'd0, -8'sd5, 1'b0, 8'd15, 1'b0};
    tv[4]  = '{-32'sd5000, 16'd1, 5'd0, 8'd0, 1'b0, 8'h80, 1'b1};
    tv[5]  = '{-32'sd5000, 16'd1, 5'd0, 8'd0, 1'b1, 8'h00, 1'b0};
    tv[6]  = '{32'd200, 16'd1, 5'd0, 8'd0, 1'b0, 8'h7f, 1'b1};
    tv[7]  = '{32'd5, 16'd1, 5'd1, 8'd0, 1'b0, 8'd3, 1'b0};
    tv[8]  = '{-32'sd5, 16'd1, 5'd1, 8'd0, 1'b0, 8'hfe, 1'b0};
    tv[9]  = '{32'd0, 16'd1, 5'd0, 8'd127, 1'b0, 8'h7f, 1'b0};
    tv[10] = '{32'd1, 16'd1, 5'd0, 8'd127, 1'b0, 8'h7f, 1'b1};
    tv[11] = '{-32'sd128, 16'd1, 5'd0, 8'd0, 1'b0, 8'h80, 1'b0};
    tv[12] = '{-32'sd129, 16'd1, 5'd0, 8'd0, 1'b0, 8'h80, 1'b1};
    tv[13] = '{32'h7fffffff, 16'hffff, 5'd31, 8'd0, 1'b0, 8'h7f, 1'b1};
    tv[14] = '{32'h80000000, 16'hffff, 5'd31, 8'd0, 1'b0, 8'h80, 1'b1};
    tv[15] = '{32'd50, 16'd1, 5'd0, 8'd0, 1'b1, 8'd50, 1'b0};
    tv[16] = '{-32'sd10, 16'd1, 5'd0, 8'd20, 1'b1, 8'd10, 1'b0};
    tv[17] = '{32'd1000, 16'd1, 5'd0, 8'd0, 1'b1, 8'h7f, 1'b1};

    in_if.data   = '0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    cfg(16'd1, 5'd0, 8'd0, 1'b0);
    width  = 8'd255;
    height = 8'd255;

    do_reset();
    chk("rst_valid", out_if.valid, 0);
    chk("rst_data", out_if.data, 0);
    chk("rst_eol", out_if.eol, 0);
    chk("rst_eof", out_if.eof, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_ready", in_if.ready, 1);

    exp_sat = 0;
    for (int i = 0; i < 18; i++) begin
      cfg(tv[i].sc, tv[i].sh, tv[i].zp, tv[i].relu);
      in_if.data  = tv[i].pix;
      in_if.valid = 1'b1;
      tick();
      in_if.valid = 1'b0;
      k = 0;
      while (!out_if.valid && k < 10) begin
        tick();
        k++;
      end
      chk($sformatf("lat%0d", i), k, 3);
      chk($sformatf("data%0d", i), out_if.data, tv[i].exp);
      exp_sat += int'(tv[i].sat);
      chk($sformatf("sat%0d", i), sat_count, exp_sat);
      pop1();
    end

    // back-pressure: 4 credits, then drain in order
    do_reset();
    cfg(16'd1, 5'd0, 8'd0, 1'b0);
    acc_n = 0;
    got   = 0;
    cyc   = 0;
    while ((acc_n < 6 || got < 6) && cyc < 60) begin
      in_if.valid  = (acc_n < 6);
      in_if.data   = 32'(10 + acc_n);
      out_if.ready = (cyc >= 12);
      if (cyc == 12) begin
        chk("bp_acc4", acc_n, 4);
        chk("bp_rdy_low", in_if.ready, 0);
      end
      will_acc = in_if.valid & in_if.ready;
      will_pop = out_if.valid & out_if.ready;
      if (will_pop) begin
        chk($sformatf("bp_ord%0d", got), out_if.data, 8'(10 + got));
        got++;
      end
      tick();
      if (will_acc) acc_n++;
      cyc++;
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    chk("bp_acc6", acc_n, 6);
    chk("bp_got6", got, 6);
    repeat (5) tick();
    chk("bp_empty", out_if.valid, 0);
    chk("bp_rdy_high", in_if.ready, 1);

    // framing 4x2, one saturating pixel, mid-frame size change
    do_reset();
    cfg(16'd1, 5'd0, 8'd0, 1'b0);
    width  = 8'd4;
    height = 8'd2;
    for (int j = 0; j < 8; j++) begin
      pv[j] = 8'(j * 3);
      ev[j] = 8'(j * 3);
    end
    acc_n = 0;
    got   = 0;
    cyc   = 0;
    out_if.ready = 1'b1;
    while ((acc_n < 8 || got < 8) && cyc < 80) begin
      in_if.valid = (acc_n < 8);
      in_if.data  = (acc_n == 2) ? 32'd300
                                 : {24'd0, pv[acc_n % 8]};
      will_acc = in_if.valid & in_if.ready;
      will_pop = out_if.valid & out_if.ready;
      if (will_pop) begin
        chk($sformatf("fr_d%0d", got), out_if.data,
            (got == 2) ? 8'h7f : ev[got % 8]);
        chk($sformatf("fr_eol%0d", got), out_if.eol,
            (got == 3 || got == 7));
        chk($sformatf("fr_eof%0d", got), out_if.eof,
            (got == 7));
        got++;
      end
      tick();
      if (will_acc) acc_n++;
      if (acc_n == 1) begin
        width  = 8'd7;
        height = 8'd9;
      end
      cyc++;
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    chk("fr_got8", got, 8);
    repeat (3) tick();
    chk("fr_sat1", sat_count, 1);

    width  = 8'd2;
    height = 8'd1;
    in_if.data  = 32'd5;
    in_if.valid = 1'b1;
    tick();
    in_if.valid = 1'b0;
    chk("fr2_satclr", sat_count, 0);
    wait_valid("fr2_v0");
    chk("fr2_d0", out_if.data, 5);
    chk("fr2_eol0", out_if.eol, 0);
    chk("fr2_eof0", out_if.eof, 0);
    pop1();
    in_if.data  = 32'd6;
    in_if.valid = 1'b1;
    tick();
    in_if.valid = 1'b0;
    wait_valid("fr2_v1");
    chk("fr2_d1", out_if.data, 6);
    chk("fr2_eol1", out_if.eol, 1);
    chk("fr2_eof1", out_if.eof, 1);
    pop1();

    // reset with 2 in FIFO and 1 in flight
    do_reset();
    cfg(16'd1, 5'd0, 8'd0, 1'b0);
    in_if.valid = 1'b1;
    in_if.data  = 32'd1;
    tick();
    in_if.data = 32'd2;
    tick();
    in_if.data = 32'd3;
    tick();
    in_if.valid = 1'b0;
    tick();
    tick();
    chk("mr_pre_valid", out_if.valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", out_if.valid, 0);
    chk("mr_data", out_if.data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    out_if.ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      seen = seen | out_if.valid;
      tick();
    end
    out_if.ready = 1'b0;
    chk("mr_nostale", seen, 0);
    chk("mr_ready", in_if.ready, 1);
    chk("mr_sat", sat_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
